// File: rtl/i2c_arb_pkg.sv
// Shared i2c definitions: engine command codes, arbiter state encodings and a grant helper.
package i2c_arb_pkg;

    localparam logic [2:0] CMD_START   = 3'd0;
    localparam logic [2:0] CMD_WRITE   = 3'd1;
    localparam logic [2:0] CMD_READ    = 3'd2;
    localparam logic [2:0] CMD_STOP    = 3'd3;
    localparam logic [2:0] CMD_RESTART = 3'd4;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_GRANTED    = 3'd1;
    localparam logic [2:0] ST_BUSY       = 3'd2;
    localparam logic [2:0] ST_FORCE_STOP = 3'd3;
    localparam logic [2:0] ST_RELEASE    = 3'd4;

    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/i2c_arb_if.sv
// Requester and byte-engine signal bundle for the two-way i2c arbiter.
interface i2c_arb_if;
    logic [1:0] req;
    logic [1:0] valid;
    logic [5:0] cmd_in;
    logic [15:0] data_in;
    logic [1:0] gnt;
    logic [1:0] accept;
    logic [1:0] done;
    logic [7:0] rdata;
    logic       rack;
    logic       timeout;
    logic       eng_write;
    logic [2:0] eng_cmd;
    logic [7:0] eng_data;
    logic       eng_ready;
    logic [7:0] eng_data_out;
    logic       eng_ack;
    logic       eng_done_tick;

    modport slave (
        input  req, valid, cmd_in, data_in, eng_ready, eng_data_out, eng_ack, eng_done_tick,
        output gnt, accept, done, rdata, rack, timeout, eng_write, eng_cmd, eng_data
    );

    modport master (
        output req, valid, cmd_in, data_in, eng_ready, eng_data_out, eng_ack, eng_done_tick,
        input  gnt, accept, done, rdata, rack, timeout, eng_write, eng_cmd, eng_data
    );
endinterface

// File: rtl/i2c_arb_rr_pick.sv
// Two-way round-robin select: on a tie the requester not served last wins.
module i2c_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);
    assign pick = (req[0] && req[1]) ? ~last : ~req[0];
endmodule

// File: rtl/i2c_arb.sv
// Two-requester arbiter in front of an i2c byte engine.
// Optional idle-grant watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arb
    import i2c_arb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    i2c_arb_if.slave   bus
);
    logic [2:0] state_reg;
    logic       owner_reg;
    logic       last_reg;
    logic       beat_stop_reg;
    logic       stop_sent_reg;
    logic [1:0] gnt_reg;
    logic [1:0] accept_reg;
    logic [1:0] done_reg;
    logic       eng_write_reg;
    logic [2:0] eng_cmd_reg;
    logic [7:0] eng_data_reg;
    logic [7:0] rdata_reg;
    logic       rack_reg;
    logic       pick;
    logic       accept_now;
    logic       req_drop;
    logic       timeout_hit;
    logic [2:0] cmd_arr  [2];
    logic [7:0] data_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign cmd_arr[gi]  = bus.cmd_in[gi*3 +: 3];
            assign data_arr[gi] = bus.data_in[gi*8 +: 8];
        end
    endgenerate

    i2c_rr_pick u_pick (
        .req  (bus.req),
        .last (last_reg),
        .pick (pick)
    );

    assign accept_now = bus.valid[owner_reg] && bus.eng_ready;
    assign req_drop   = !bus.req[owner_reg];

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_reg;
    logic        timeout_reg;

    assign timeout_hit = (state_reg == ST_GRANTED) && !req_drop && !accept_now &&
                         (to_cnt_reg == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (reset || state_reg != ST_GRANTED || accept_now) begin
            to_cnt_reg <= 16'd0;
        end else begin
            to_cnt_reg <= to_cnt_reg + 16'd1;
        end
        timeout_reg <= !reset && timeout_hit;
    end

    assign bus.timeout = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    // The limit only matters to the watchdog; referencing it keeps the parameter live.
    assign bus.timeout = 1'b0 & (TIMEOUT_CYCLES != 16'd0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b1;
            beat_stop_reg <= 1'b0;
            stop_sent_reg <= 1'b0;
            gnt_reg       <= 2'b00;
            accept_reg    <= 2'b00;
            done_reg      <= 2'b00;
            eng_write_reg <= 1'b0;
            eng_cmd_reg   <= 3'd0;
            eng_data_reg  <= 8'd0;
            rdata_reg     <= 8'd0;
            rack_reg      <= 1'b0;
        end else begin
            accept_reg    <= 2'b00;
            done_reg      <= 2'b00;
            eng_write_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|bus.req) begin
                        owner_reg <= pick;
                        gnt_reg   <= onehot2(pick);
                        state_reg <= ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    // A vanished owner takes precedence over any beat it still offers.
                    if (req_drop || timeout_hit) begin
                        stop_sent_reg <= 1'b0;
                        state_reg     <= ST_FORCE_STOP;
                    end else if (accept_now) begin
                        eng_cmd_reg   <= cmd_arr[owner_reg];
                        eng_data_reg  <= data_arr[owner_reg];
                        eng_write_reg <= 1'b1;
                        accept_reg    <= onehot2(owner_reg);
                        beat_stop_reg <= (cmd_arr[owner_reg] == CMD_STOP);
                        state_reg     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.eng_done_tick) begin
                        done_reg  <= onehot2(owner_reg);
                        rdata_reg <= bus.eng_data_out;
                        rack_reg  <= bus.eng_ack;
                        state_reg <= beat_stop_reg ? ST_RELEASE : ST_GRANTED;
                    end
                end
                ST_FORCE_STOP: begin
                    if (!stop_sent_reg && bus.eng_ready) begin
                        eng_cmd_reg   <= CMD_STOP;
                        eng_data_reg  <= 8'd0;
                        eng_write_reg <= 1'b1;
                        stop_sent_reg <= 1'b1;
                    end else if (stop_sent_reg && bus.eng_done_tick) begin
                        state_reg <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    gnt_reg   <= 2'b00;
                    last_reg  <= owner_reg;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.accept    = accept_reg;
    assign bus.done      = done_reg;
    assign bus.rdata     = rdata_reg;
    assign bus.rack      = rack_reg;
    assign bus.eng_write = eng_write_reg;
    assign bus.eng_cmd   = eng_cmd_reg;
    assign bus.eng_data  = eng_data_reg;
endmodule

// File: tb/tb_i2c_arb.sv
// Directed bench for i2c_arb: cycle vector table plus hand sequences for arbitration,
// forced release, grant hold/watchdog and mid-beat reset.
module tb_i2c_arb;
    import i2c_arb_pkg::*;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_CYCLES = 16'd20;
`else
    localparam logic [15:0] TO_CYCLES = 16'd50000;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    i2c_arb_if bus ();

    i2c_arb #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  valid;
        logic [5:0]  cmd;
        logic [15:0] data;
        logic        rdy;
        logic        tick;
        logic [7:0]  edo;
        logic        eack;
        logic [1:0]  gnt;
        logic [1:0]  acc;
        logic [1:0]  done;
        logic        ew;
        logic [2:0]  ecmd;
        logic [7:0]  edata;
        logic [7:0]  rdata;
        logic        rack;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] valid, input logic [5:0] cmd,
                         input logic [15:0] data, input logic rdy, input logic tick,
                         input logic [7:0] edo, input logic eack);
        bus.req           = req;
        bus.valid         = valid;
        bus.cmd_in        = cmd;
        bus.data_in       = data;
        bus.eng_ready     = rdy;
        bus.eng_done_tick = tick;
        bus.eng_data_out  = edo;
        bus.eng_ack       = eack;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 6'd0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        int to_at;

        //          req    valid  cmd    data      rdy  tick edo    eack   gnt    acc    done   ew   ecmd  edata  rdata  rack
        vecs[0]  = '{2'b01, 2'b00, 6'o00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{2'b01, 2'b01, 6'o00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{2'b01, 2'b00, 6'o00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{2'b01, 2'b00, 6'o00, 16'h0000, 1'b0, 1'b1, 8'h00, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{2'b01, 2'b01, 6'o01, 16'h004E, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{2'b01, 2'b11, 6'o21, 16'hFF4E, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 3'd1, 8'h4E, 8'h00, 1'b0};
        vecs[6]  = '{2'b01, 2'b00, 6'o00, 16'h0000, 1'b0, 1'b1, 8'h00, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 3'd1, 8'h4E, 8'h00, 1'b1};
        vecs[7]  = '{2'b01, 2'b01, 6'o02, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 3'd2, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{2'b01, 2'b00, 6'o00, 16'h0000, 1'b0, 1'b1, 8'hA5, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 3'd2, 8'h00, 8'hA5, 1'b0};
        vecs[9]  = '{2'b01, 2'b00, 6'o00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 3'd2, 8'h00, 8'hA5, 1'b0};
        vecs[10] = '{2'b01, 2'b01, 6'o03, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 3'd3, 8'h00, 8'hA5, 1'b0};
        vecs[11] = '{2'b00, 2'b00, 6'o00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 3'd3, 8'h00, 8'hA5, 1'b0};
        vecs[12] = '{2'b00, 2'b00, 6'o00, 16'h0000, 1'b0, 1'b1, 8'h3C, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 3'd3, 8'h00, 8'h3C, 1'b1};
        vecs[13] = '{2'b00, 2'b00, 6'o00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'd3, 8'h00, 8'h3C, 1'b1};
        vecs[14] = '{2'b00, 2'b00, 6'o00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'd3, 8'h00, 8'h3C, 1'b1};

        do_reset();
        chk("rst_gnt", 16'(bus.gnt), 16'h0);
        chk("rst_accept", 16'(bus.accept), 16'h0);
        chk("rst_done", 16'(bus.done), 16'h0);
        chk("rst_eng_write", 16'(bus.eng_write), 16'h0);
        chk("rst_eng_cmd", 16'(bus.eng_cmd), 16'h0);
        chk("rst_eng_data", 16'(bus.eng_data), 16'h0);
        chk("rst_rdata", 16'(bus.rdata), 16'h0);
        chk("rst_rack", 16'(bus.rack), 16'h0);
        chk("rst_timeout", 16'(bus.timeout), 16'h0);
        $display("reset: gnt=%b eng_write=%b", bus.gnt, bus.eng_write);

        // Requester 0 alone: START, stalled then accepted WRITE 0x4E, READ 0xA5, STOP.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].req, vecs[i].valid, vecs[i].cmd, vecs[i].data,
                  vecs[i].rdy, vecs[i].tick, vecs[i].edo, vecs[i].eack);
            step();
            chk($sformatf("v%0d_gnt", i), 16'(bus.gnt), 16'(vecs[i].gnt));
            chk($sformatf("v%0d_accept", i), 16'(bus.accept), 16'(vecs[i].acc));
            chk($sformatf("v%0d_done", i), 16'(bus.done), 16'(vecs[i].done));
            chk($sformatf("v%0d_eng_write", i), 16'(bus.eng_write), 16'(vecs[i].ew));
            chk($sformatf("v%0d_eng_cmd", i), 16'(bus.eng_cmd), 16'(vecs[i].ecmd));
            chk($sformatf("v%0d_eng_data", i), 16'(bus.eng_data), 16'(vecs[i].edata));
            chk($sformatf("v%0d_rdata", i), 16'(bus.rdata), 16'(vecs[i].rdata));
            chk($sformatf("v%0d_rack", i), 16'(bus.rack), 16'(vecs[i].rack));
            $display("vec %0d: gnt=%b accept=%b done=%b eng_write=%b eng_cmd=%0d eng_data=%h rdata=%h rack=%b",
                     i, bus.gnt, bus.accept, bus.done, bus.eng_write, bus.eng_cmd, bus.eng_data, bus.rdata, bus.rack);
        end

        // Simultaneous requests: 0 first, 1 after one dead cycle, then 0 again.
        do_reset();
        drive(2'b11, 2'b00, 6'o00, 16'h0, 1'b1, 1'b0, 8'h0, 1'b0);
        step(); chk("rr_first_gnt", 16'(bus.gnt), 16'b01);
        bus.valid = 2'b01; bus.cmd_in = 6'o03;
        step(); chk("rr_acc0", 16'(bus.accept), 16'b01);
        bus.valid = 2'b00; bus.eng_done_tick = 1'b1;
        step(); chk("rr_done0", 16'(bus.done), 16'b01);
        bus.eng_done_tick = 1'b0;
        step(); chk("rr_dead1", 16'(bus.gnt), 16'b00);
        step(); chk("rr_second_gnt", 16'(bus.gnt), 16'b10);
        bus.valid = 2'b10; bus.cmd_in = 6'o30;
        step(); chk("rr_acc1", 16'(bus.accept), 16'b10);
        chk("rr_cmd1", 16'(bus.eng_cmd), 16'(CMD_STOP));
        bus.valid = 2'b00; bus.eng_done_tick = 1'b1;
        step(); chk("rr_done1", 16'(bus.done), 16'b10);
        bus.eng_done_tick = 1'b0;
        step(); chk("rr_dead2", 16'(bus.gnt), 16'b00);
        step(); chk("rr_third_gnt", 16'(bus.gnt), 16'b01);
        $display("round-robin: third grant gnt=%b", bus.gnt);

        // Requester 0 drops req after START: forced STOP, then requester 1.
        do_reset();
        drive(2'b11, 2'b00, 6'o00, 16'h0, 1'b1, 1'b0, 8'h0, 1'b0);
        step(); chk("fs_gnt0", 16'(bus.gnt), 16'b01);
        bus.valid = 2'b01; bus.cmd_in = 6'o00;
        step(); chk("fs_acc_start", 16'(bus.accept), 16'b01);
        bus.valid = 2'b00; bus.eng_done_tick = 1'b1;
        step(); chk("fs_done_start", 16'(bus.done), 16'b01);
        bus.eng_done_tick = 1'b0; bus.req = 2'b10;
        step(); chk("fs_no_write_yet", 16'(bus.eng_write), 16'h0);
        step(); chk("fs_stop_write", 16'(bus.eng_write), 16'h1);
        chk("fs_stop_cmd", 16'(bus.eng_cmd), 16'(CMD_STOP));
        chk("fs_no_accept", 16'(bus.accept), 16'h0);
        bus.eng_ready = 1'b0;
        step(); chk("fs_single_write", 16'(bus.eng_write), 16'h0);
        bus.eng_done_tick = 1'b1; bus.eng_ready = 1'b1;
        step(); chk("fs_no_done", 16'(bus.done), 16'h0);
        bus.eng_done_tick = 1'b0;
        step(); chk("fs_released", 16'(bus.gnt), 16'b00);
        step(); chk("fs_gnt1", 16'(bus.gnt), 16'b10);
        $display("force-stop: gnt=%b after release", bus.gnt);

        // Grant held with no traffic.
        do_reset();
        drive(2'b01, 2'b00, 6'o00, 16'h0, 1'b1, 1'b0, 8'h0, 1'b0);
        step(); chk("hold_gnt", 16'(bus.gnt), 16'b01);
`ifdef I2C_ARB_TIMEOUT_EN
        to_at = 0;
        for (k = 1; k <= 40; k++) begin
            step();
            if (bus.timeout === 1'b1) begin
                to_at = k;
                break;
            end
        end
        chk("to_cycle", 16'(to_at), 16'd20);
        step(); chk("to_pulse_width", 16'(bus.timeout), 16'h0);
        chk("to_stop_write", 16'(bus.eng_write), 16'h1);
        chk("to_stop_cmd", 16'(bus.eng_cmd), 16'(CMD_STOP));
        $display("timeout: pulse after %0d granted cycles", to_at);
`else
        to_at = 0;
        for (k = 1; k <= 100; k++) begin
            step();
            if (bus.timeout !== 1'b0 || bus.gnt !== 2'b01) to_at++;
        end
        chk("hold_bad_cycles", 16'(to_at), 16'd0);
        chk("hold_gnt_100", 16'(bus.gnt), 16'b01);
        $display("hold: gnt=%b after 100 idle cycles", bus.gnt);
`endif

        // Reset in the middle of a WRITE beat.
        do_reset();
        drive(2'b01, 2'b00, 6'o00, 16'h0, 1'b1, 1'b0, 8'h0, 1'b0);
        step();
        bus.valid = 2'b01; bus.cmd_in = 6'o01; bus.data_in = 16'h004E;
        step(); chk("mr_write_data", 16'(bus.eng_data), 16'h4E);
        reset = 1'b1; bus.valid = 2'b00;
        step();
        chk("mr_gnt", 16'(bus.gnt), 16'h0);
        chk("mr_eng_write", 16'(bus.eng_write), 16'h0);
        chk("mr_eng_cmd", 16'(bus.eng_cmd), 16'h0);
        chk("mr_eng_data", 16'(bus.eng_data), 16'h0);
        chk("mr_accept", 16'(bus.accept), 16'h0);
        reset = 1'b0; bus.req = 2'b00;
        step(); chk("mr_idle_gnt", 16'(bus.gnt), 16'h0);
        chk("mr_no_stop", 16'(bus.eng_write), 16'h0);
        bus.req = 2'b10;
        step(); chk("mr_new_gnt", 16'(bus.gnt), 16'b10);
        $display("mid-beat reset: gnt=%b", bus.gnt);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
